controller: RTL and testbench

Multi-cycle control unit driving the 16-bit windowed-register CPU datapath. It consumes the `opcode`/`func` fields the datapath extracts from the current instruction and sequences each instruction through fetch, decode, execute, memory and write-back. It issues the datapath control strobes, plus PC/IR write enables and a request/ready handshake toward data memory. It sits beside the datapath in the CPU top level.

---
 rtl/ctrl_pkg.sv | 57 +++++
 rtl/inst_decoder.sv | 46 ++++
 rtl/controller.sv | 130 +++++++++++++
 tb/tb_controller.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants and types for the multi-cycle CPU controller.
// Opcodes, func bit indices, one-hot ALU ops, FSM state and instruction class.
package ctrl_pkg;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_JUMP  = 4'b0010;
  localparam logic [3:0] OP_BRZ   = 4'b0100;
  localparam logic [3:0] OP_RTYPE = 4'b1000;
  localparam logic [3:0] OP_ADDI  = 4'b1100;
  localparam logic [3:0] OP_SUBI  = 4'b1101;
  localparam logic [3:0] OP_ANDI  = 4'b1110;
  localparam logic [3:0] OP_ORI   = 4'b1111;

  localparam int F_MOVE = 0;
  localparam int F_ADD  = 1;
  localparam int F_SUB  = 2;
  localparam int F_AND  = 3;
  localparam int F_OR   = 4;
  localparam int F_NOT  = 5;
  localparam int F_NOP  = 6;
  localparam int F_WND  = 7;

  localparam logic [6:0] ALU_NONE = 7'h00;
  localparam logic [6:0] ALU_MOVE = 7'h01;
  localparam logic [6:0] ALU_ADD  = 7'h02;
  localparam logic [6:0] ALU_SUB  = 7'h04;
  localparam logic [6:0] ALU_AND  = 7'h08;
  localparam logic [6:0] ALU_OR   = 7'h10;
  localparam logic [6:0] ALU_NOT  = 7'h20;
  localparam logic [6:0] ALU_CMP  = 7'h40;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB
  } state_t;

  typedef enum logic [3:0] {
    ALU,
    ALUI,
    LOAD,
    STORE,
    JUMP,
    BRZ,
    WND,
    NOP,
    ILLEGAL
  } iclass_t;

  function automatic logic is_onehot8(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

endpackage

// File: rtl/inst_decoder.sv
// Combinational instruction classifier.
// Maps opcode/func to an instruction class and its one-hot ALU op.
module inst_decoder
  import ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [7:0] func,
  output iclass_t    iclass,
  output logic [6:0] aluop
);

  always_comb begin
    iclass = ILLEGAL;
    aluop  = ALU_NONE;
    case (opcode)
      OP_LOAD:  iclass = LOAD;
      OP_STORE: iclass = STORE;
      OP_JUMP:  iclass = JUMP;
      OP_BRZ: begin
        iclass = BRZ;
        aluop  = ALU_CMP;
      end
      OP_RTYPE: begin
        if (is_onehot8(func)) begin
          unique case (1'b1)
            func[F_MOVE]: begin iclass = ALU; aluop = ALU_MOVE; end
            func[F_ADD]:  begin iclass = ALU; aluop = ALU_ADD;  end
            func[F_SUB]:  begin iclass = ALU; aluop = ALU_SUB;  end
            func[F_AND]:  begin iclass = ALU; aluop = ALU_AND;  end
            func[F_OR]:   begin iclass = ALU; aluop = ALU_OR;   end
            func[F_NOT]:  begin iclass = ALU; aluop = ALU_NOT;  end
            func[F_NOP]:  iclass = NOP;
            func[F_WND]:  iclass = WND;
            default:      iclass = ILLEGAL;
          endcase
        end
      end
      OP_ADDI: begin iclass = ALUI; aluop = ALU_ADD; end
      OP_SUBI: begin iclass = ALUI; aluop = ALU_SUB; end
      OP_ANDI: begin iclass = ALUI; aluop = ALU_AND; end
      OP_ORI:  begin iclass = ALUI; aluop = ALU_OR;  end
      default: iclass = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/controller.sv
// Multi-cycle control FSM for the 16-bit windowed-register CPU.
// Sequences FETCH/DECODE/EXEC/MEM/WB and issues datapath strobes.
module controller
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic [7:0] func,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       jump,
  output logic       immdSel,
  output logic       memOrALU,
  output logic       toWrite,
  output logic       setWindow,
  output logic [6:0] ALUop,
  output logic       illegal
);

  state_t     state, state_n;
  iclass_t    cls_q;
  iclass_t    dec_cls;
  logic [6:0] dec_aluop;
  logic [6:0] aluop_q;

  inst_decoder u_dec (
    .opcode (opcode),
    .func   (func),
    .iclass (dec_cls),
    .aluop  (dec_aluop)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FETCH;
      cls_q   <= NOP;
      aluop_q <= ALU_NONE;
    end else begin
      state <= state_n;
      if (state == DECODE) begin
        cls_q   <= dec_cls;
        aluop_q <= dec_aluop;
      end
    end
  end

  // Outputs are forced low while reset is held, independent of the clock.
  always_comb begin
    state_n   = state;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    jump      = 1'b0;
    immdSel   = 1'b0;
    memOrALU  = 1'b0;
    toWrite   = 1'b0;
    setWindow = 1'b0;
    ALUop     = ALU_NONE;
    illegal   = 1'b0;
    if (rst) begin
      case (state)
        FETCH: begin
          ir_write = 1'b1;
          state_n  = DECODE;
        end
        DECODE: begin
          if (dec_cls == LOAD || dec_cls == STORE)
            state_n = MEM;
          else
            state_n = EXEC;
        end
        EXEC: begin
          state_n = FETCH;
          case (cls_q)
            ALU, ALUI: begin
              ALUop    = aluop_q;
              immdSel  = (cls_q == ALUI);
              state_n  = WB;
            end
            JUMP: begin
              jump     = 1'b1;
              pc_write = 1'b1;
            end
            BRZ: begin
              ALUop    = aluop_q;
              pc_write = 1'b1;
            end
            WND: begin
              setWindow = 1'b1;
              pc_write  = 1'b1;
            end
            default: begin
              pc_write = 1'b1;
              illegal  = (cls_q == ILLEGAL);
            end
          endcase
        end
        MEM: begin
          mem_req   = 1'b1;
          mem_write = (cls_q == STORE);
          if (mem_ready) begin
            if (cls_q == STORE) begin
              pc_write = 1'b1;
              state_n  = FETCH;
            end else begin
              state_n  = WB;
            end
          end
        end
        WB: begin
          toWrite  = 1'b1;
          pc_write = 1'b1;
          state_n  = FETCH;
          if (cls_q != LOAD) begin
            ALUop    = aluop_q;
            immdSel  = (cls_q == ALUI);
            memOrALU = 1'b1;
          end
        end
        default: state_n = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_controller.sv
// Randomized self-checking bench for controller.
// Expected per-cycle strobes come from an instruction-level timeline model.
module tb_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic [7:0] func;
  logic       mem_ready;
  logic       mem_req, mem_write, ir_write, pc_write, jump;
  logic       immdSel, memOrALU, toWrite, setWindow, illegal;
  logic [6:0] ALUop;

  int errors = 0;
  int checks = 0;

  localparam logic [16:0] MREQ = 17'h10000;
  localparam logic [16:0] MWR  = 17'h08000;
  localparam logic [16:0] IRW  = 17'h04000;
  localparam logic [16:0] PCW  = 17'h02000;
  localparam logic [16:0] JMP  = 17'h01000;
  localparam logic [16:0] IMM  = 17'h00800;
  localparam logic [16:0] MOA  = 17'h00400;
  localparam logic [16:0] TOW  = 17'h00200;
  localparam logic [16:0] SETW = 17'h00100;
  localparam logic [16:0] ILL  = 17'h00080;

  typedef struct {
    logic [16:0] exp;
    bit          dec;
    bit          in_mem;
    bit          rdy;
  } cyc_t;

  cyc_t exp_q[$];

  wire [16:0] outs = {mem_req, mem_write, ir_write, pc_write, jump,
                      immdSel, memOrALU, toWrite, setWindow, illegal,
                      ALUop};

  controller dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .func      (func),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_write (mem_write),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .jump      (jump),
    .immdSel   (immdSel),
    .memOrALU  (memOrALU),
    .toWrite   (toWrite),
    .setWindow (setWindow),
    .ALUop     (ALUop),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [16:0] got,
                       input logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  function automatic cyc_t mk(input logic [16:0] e, input bit d,
                              input bit m, input bit r);
    cyc_t c;
    c.exp = e; c.dec = d; c.in_mem = m; c.rdy = r;
    return c;
  endfunction

  // Timeline of one instruction: FETCH, DECODE, then class-dependent tail.
  task automatic build(input logic [3:0] op, input logic [7:0] fn,
                       input int w);
    logic [16:0] ex;
    logic [6:0]  alu;
    bit          legal_rt, has_wb;
    exp_q.delete();
    exp_q.push_back(mk(IRW, 0, 0, 0));
    exp_q.push_back(mk('0, 1, 0, 0));
    legal_rt = ($countones(fn) == 1);
    has_wb = 0;
    alu = '0;
    ex = PCW | ILL;
    if (op == 4'd0 || op == 4'd1) begin
      for (int i = 0; i < w; i++)
        exp_q.push_back(mk(MREQ | (op == 1 ? MWR : '0), 0, 1, 0));
      if (op == 4'd1) begin
        exp_q.push_back(mk(MREQ | MWR | PCW, 0, 1, 1));
      end else begin
        exp_q.push_back(mk(MREQ, 0, 1, 1));
        exp_q.push_back(mk(TOW | PCW, 0, 0, 0));
      end
      return;
    end
    if (op == 4'd2) ex = PCW | JMP;
    else if (op == 4'd4) ex = PCW | 17'h40;
    else if (op == 4'd8 && legal_rt) begin
      if (fn[7]) ex = PCW | SETW;
      else if (fn[6]) ex = PCW;
      else begin
        alu = {1'b0, fn[5:0]};
        ex = {10'd0, alu};
        has_wb = 1;
      end
    end else if (op >= 4'd12) begin
      alu = 7'h02 << (op - 4'd12);
      ex = IMM | {10'd0, alu};
      has_wb = 1;
    end
    exp_q.push_back(mk(ex, 0, 0, 0));
    if (has_wb)
      exp_q.push_back(mk(ex | TOW | PCW | MOA, 0, 0, 0));
  endtask

  // Starts and ends just after a falling edge with the DUT in FETCH.
  task automatic run(input logic [3:0] op, input logic [7:0] fn,
                     input int w, input string tag);
    build(op, fn, w);
    foreach (exp_q[i]) begin
      if (exp_q[i].dec) begin
        opcode = op;
        func   = fn;
      end else begin
        opcode = 4'($urandom);
        func   = 8'($urandom);
      end
      mem_ready = exp_q[i].in_mem ? exp_q[i].rdy : 1'($urandom);
      #1;
      check($sformatf("%s c%0d", tag, i), outs, exp_q[i].exp);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [3:0] rop;
    logic [7:0] rfn;
    rst = 1'b0;
    opcode = 4'h8;
    func = 8'h02;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1 check("reset", outs, '0);
    @(negedge clk);
    rst = 1'b1;
    run(4'h8, 8'h02, 0, "add");
    run(4'h0, 8'h00, 3, "load_w3");
    run(4'h1, 8'h00, 0, "store_w0");
    run(4'h2, 8'h00, 0, "jump");
    run(4'h4, 8'h00, 0, "brz");
    run(4'h8, 8'h80, 0, "wnd");
    run(4'h8, 8'h40, 0, "nop");
    run(4'h3, 8'h00, 0, "ill_op");
    run(4'h8, 8'h03, 0, "ill_fn");
    run(4'h8, 8'h00, 0, "ill_zero");
    run(4'hd, 8'h55, 0, "subi");
    run(4'h8, 8'h20, 0, "not");
    opcode = 4'h0; func = 8'h00; mem_ready = 1'b0;
    #1 check("mr fetch", outs, IRW);
    @(negedge clk);
    #1 check("mr decode", outs, '0);
    @(negedge clk);
    #1 check("mr mem", outs, MREQ);
    rst = 1'b0;
    #1 check("mr reset", outs, '0);
    @(negedge clk);
    #1 check("mr held", outs, '0);
    rst = 1'b1;
    run(4'h1, 8'h00, 2, "post_rst");
    for (int n = 0; n < 200; n++) begin
      rop = 4'($urandom);
      if ($urandom_range(0, 1) == 0)
        rfn = 8'h01 << $urandom_range(0, 7);
      else
        rfn = 8'($urandom);
      run(rop, rfn, $urandom_range(0, 4), $sformatf("rnd%0d", n));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
